// File: rtl/hyper_req_arbiter.sv
// Round-robin arbiter: NUM_REQ requesters share one hyper_xface command port with one transaction in flight.
// Optional watchdog under HYPER_ARB_TIMEOUT_EN (sticky arb_err, 32'hDEAD_BEEF read data on timeout).
module hyper_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [32*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    input  logic [4*NUM_REQ-1:0]  req_be,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  xf_rd_req,
    output logic                  xf_wr_req,
    output logic [31:0]           xf_addr,
    output logic [31:0]           xf_wr_d,
    output logic [3:0]            xf_wr_byte_en,
    input  logic [31:0]           xf_rd_d,
    input  logic                  xf_rd_rdy,
    input  logic                  xf_busy,
    output logic                  arb_err
);
    localparam int GW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     gnt;
    logic              gnt_we;
    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic              win_we;
    logic [31:0]       win_addr;
    logic [31:0]       win_wdata;
    logic [3:0]        win_be;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic              grant_load;
    logic              rd_capture;
`ifdef HYPER_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]     tmo_cnt;
    logic              tmo_hit;
`endif

    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[GW-1:0];
    endfunction

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[rr_index(rr_ptr, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(rr_ptr, i);
            end
        end
    end

    always_comb begin
        win_we     = 1'b0;
        win_addr   = '0;
        win_wdata  = '0;
        win_be     = '0;
        win_onehot = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_we        = req_we[i];
                win_addr      = req_addr[32*i +: 32];
                win_wdata     = req_wdata[32*i +: 32];
                win_be        = req_be[4*i +: 4];
                win_onehot[i] = win_found;
            end
            gnt_onehot[i] = (gnt == GW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        rd_capture = 1'b0;
`ifdef HYPER_ARB_TIMEOUT_EN
        tmo_hit    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_found && !xf_busy) begin
                    grant_load = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                // A fast controller may return read data before busy is ever seen.
                if (!gnt_we && xf_rd_rdy) begin
                    rd_capture = 1'b1;
                    state_d    = ST_RESP;
                end else if (xf_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (gnt_we ? !xf_busy : xf_rd_rdy) begin
                    rd_capture = !gnt_we;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
`ifdef HYPER_ARB_TIMEOUT_EN
        if ((state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE) && state_d != ST_RESP
            && tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit = 1'b1;
            state_d = ST_RESP;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready     <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            xf_rd_req     <= 1'b0;
            xf_wr_req     <= 1'b0;
            xf_addr       <= '0;
            xf_wr_d       <= '0;
            xf_wr_byte_en <= '0;
            gnt           <= '0;
            gnt_we        <= 1'b0;
            rr_ptr        <= '0;
        end else begin
            req_ready <= grant_load ? win_onehot : '0;
            xf_wr_req <= grant_load & win_we;
            xf_rd_req <= grant_load & ~win_we;
            rsp_valid <= (state_d == ST_RESP) ? gnt_onehot : '0;
            if (grant_load) begin
                gnt           <= win_idx;
                gnt_we        <= win_we;
                xf_addr       <= win_addr;
                xf_wr_d       <= win_wdata;
                xf_wr_byte_en <= win_be;
            end
            if (rd_capture) rsp_rdata <= xf_rd_d;
`ifdef HYPER_ARB_TIMEOUT_EN
            else if (tmo_hit && !gnt_we) rsp_rdata <= 32'hDEAD_BEEF;
`endif
            if (state_q == ST_RESP)
                rr_ptr <= (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
        end
    end

`ifdef HYPER_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            arb_err <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE)
                tmo_cnt <= '0;
            else if (state_q == ST_WAIT_ACK || state_q == ST_WAIT_DONE)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) arb_err <= 1'b1;
        end
    end
`else
    // No watchdog: the FSM waits on the controller indefinitely and the flag stays low.
    assign arb_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_hyper_req_arbiter.sv
// Directed bench for hyper_req_arbiter with a behavioural hyper_xface stub and table-driven transactions.
module tb_hyper_req_arbiter;
    localparam int NREQ  = 2;
    localparam int TMO   = 16;
    localparam int BOUND = 60;
    localparam int NV    = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid, req_we;
    logic [32*NREQ-1:0]  req_addr, req_wdata;
    logic [4*NREQ-1:0]   req_be;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [31:0]         rsp_rdata, xf_addr, xf_wr_d, xf_rd_d;
    logic                xf_rd_req, xf_wr_req, xf_rd_rdy, xf_busy, arb_err;
    logic [3:0]          xf_wr_byte_en;

    logic                stub_busy, force_busy, stub_hang, stub_we;
    int                  stub_lat, stub_cnt;
    logic [31:0]         stub_addr, stub_wd;
    logic [3:0]          stub_be;
    logic [31:0]         mem [256];

    int checks = 0;
    int errors = 0;
    int grant_log [$];
    int cmd_cnt = 0, rsp_cnt = 0, overlap_cnt = 0, outstanding = 0;

    logic [127:0] all_outs;
    assign all_outs = {21'd0, req_ready, rsp_valid, rsp_rdata, xf_rd_req, xf_wr_req,
                       xf_addr, xf_wr_d, xf_wr_byte_en, arb_err};
    assign xf_busy = stub_busy | force_busy;

    typedef struct {
        int          id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [NV];

    hyper_req_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .xf_rd_req(xf_rd_req), .xf_wr_req(xf_wr_req), .xf_addr(xf_addr),
        .xf_wr_d(xf_wr_d), .xf_wr_byte_en(xf_wr_byte_en),
        .xf_rd_d(xf_rd_d), .xf_rd_rdy(xf_rd_rdy), .xf_busy(xf_busy),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    // Controller stub: busy from the command cycle, completes after stub_lat cycles.
    always @(negedge clk) begin
        if (reset) begin
            stub_busy = 1'b0;
            stub_cnt  = 0;
            xf_rd_rdy = 1'b0;
        end else begin
            xf_rd_rdy = 1'b0;
            if (stub_cnt != 0) begin
                if (!stub_hang) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        if (stub_we) begin
                            for (int b = 0; b < 4; b++)
                                if (stub_be[b]) mem[stub_addr[7:0]][8*b +: 8] = stub_wd[8*b +: 8];
                        end else begin
                            xf_rd_d   = mem[stub_addr[7:0]];
                            xf_rd_rdy = 1'b1;
                        end
                        stub_busy = 1'b0;
                    end
                end
            end else if (xf_wr_req || xf_rd_req) begin
                stub_we   = xf_wr_req;
                stub_addr = xf_addr;
                stub_wd   = xf_wr_d;
                stub_be   = xf_wr_byte_en;
                stub_busy = 1'b1;
                stub_cnt  = stub_lat;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) grant_log.push_back(i);
            if (xf_wr_req || xf_rd_req) begin
                cmd_cnt++;
                if (outstanding != 0 || (xf_wr_req && xf_rd_req)) overlap_cnt++;
                outstanding++;
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                if (outstanding != 0) outstanding--;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == '0 && n < BOUND);
        checks++;
        if (req_ready == '0) begin
            errors++;
            $display("FAIL %s: no req_ready within %0d cycles", name, BOUND);
        end
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < BOUND);
        checks++;
        if (rsp_valid == '0) begin
            errors++;
            $display("FAIL %s: no rsp_valid within %0d cycles", name, BOUND);
        end
    endtask

    task automatic drive(input int id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        req_valid[id]           = 1'b1;
        req_we[id]              = we;
        req_addr[32*id +: 32]   = addr;
        req_wdata[32*id +: 32]  = wdata;
        req_be[4*id +: 4]       = be;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int id);
        logic [NREQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

    initial begin
        int n, g0, r0, c0;
        int remaining [NREQ];
        int exp_order [6];

        vecs[0] = '{0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 32'h0000_0000};
        vecs[1] = '{1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 32'h0000_0000};
        vecs[2] = '{0, 1'b0, 32'h20, 32'h0,         4'h0, 32'hCAFE_F00D};
        vecs[3] = '{1, 1'b1, 32'h30, 32'h1122_3344, 4'h5, 32'hCAFE_F00D};
        vecs[4] = '{1, 1'b0, 32'h30, 32'h0,         4'h0, 32'h0022_0044};
        vecs[5] = '{0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hA5A5_1234};
        vecs[6] = '{0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h8, 32'hA5A5_1234};
        vecs[7] = '{1, 1'b0, 32'h10, 32'h0,         4'h0, 32'hFFA5_1234};
        exp_order = '{0, 1, 0, 1, 0, 1};

        for (int a = 0; a < 256; a++) mem[a] = '0;
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        xf_rd_d = '0; xf_rd_rdy = 1'b0;
        stub_busy = 1'b0; force_busy = 1'b0; stub_hang = 1'b0; stub_lat = 2; stub_cnt = 0;
        stub_we = 1'b0; stub_addr = '0; stub_wd = '0; stub_be = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs, 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outs, 128'(0));

        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].id, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be);
            wait_ready($sformatf("v%0d_ready_wait", v));
            check($sformatf("v%0d_req_ready", v), 128'(req_ready), 128'(onehot(vecs[v].id)));
            check($sformatf("v%0d_xf_wr_req", v), 128'(xf_wr_req), 128'(vecs[v].we));
            check($sformatf("v%0d_xf_rd_req", v), 128'(xf_rd_req), 128'(!vecs[v].we));
            check($sformatf("v%0d_xf_addr", v), 128'(xf_addr), 128'(vecs[v].addr));
            check($sformatf("v%0d_xf_wr_d", v), 128'(xf_wr_d), 128'(vecs[v].wdata));
            check($sformatf("v%0d_xf_be", v), 128'(xf_wr_byte_en), 128'(vecs[v].be));
            req_valid[vecs[v].id] = 1'b0;
            wait_rsp($sformatf("v%0d_rsp_wait", v));
            check($sformatf("v%0d_rsp_valid", v), 128'(rsp_valid), 128'(onehot(vecs[v].id)));
            check($sformatf("v%0d_rsp_rdata", v), 128'(rsp_rdata), 128'(vecs[v].exp_rdata));
            check($sformatf("v%0d_arb_err", v), 128'(arb_err), 128'(0));
        end

        // Contention: both requesters hold requests continuously, three each.
        grant_log.delete();
        c0 = cmd_cnt; r0 = rsp_cnt;
        remaining[0] = 3; remaining[1] = 3;
        drive(0, 1'b1, 32'h40, 32'h1000_0000, 4'hF);
        drive(1, 1'b1, 32'h50, 32'h2000_0000, 4'hF);
        n = 0;
        while ((remaining[0] != 0 || remaining[1] != 0 || rsp_cnt - r0 < 6) && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && remaining[i] != 0) begin
                    remaining[i]--;
                    if (remaining[i] == 0) req_valid[i] = 1'b0;
                    else drive(i, 1'b1, 32'h40 + 32'(16*i) + 32'(3 - remaining[i]),
                               32'h1000_0000 * 32'(i + 1) + 32'(3 - remaining[i]), 4'hF);
                end
            end
        end
        repeat (3) @(negedge clk);
        check("cont_grants", 128'(grant_log.size()), 128'(6));
        for (int k = 0; k < 6; k++)
            check($sformatf("cont_order_%0d", k),
                  128'((k < grant_log.size()) ? grant_log[k] : -1), 128'(exp_order[k]));
        check("cont_cmds", 128'(cmd_cnt - c0), 128'(6));
        check("cont_rsps", 128'(rsp_cnt - r0), 128'(6));
        check("cont_overlap", 128'(overlap_cnt), 128'(0));

        // Busy hold-off in IDLE.
        force_busy = 1'b1;
        drive(0, 1'b0, 32'h20, 32'h0, 4'h0);
        g0 = grant_log.size();
        repeat (6) @(negedge clk);
        check("busy_no_ready", 128'(grant_log.size() - g0), 128'(0));
        force_busy = 1'b0;
        @(negedge clk);
        check("busy_grant_next", 128'(req_ready), 128'(2'b01));
        req_valid[0] = 1'b0;
        wait_rsp("busy_rsp_wait");
        check("busy_rsp_valid", 128'(rsp_valid), 128'(2'b01));
        check("busy_rsp_rdata", 128'(rsp_rdata), 128'(32'hCAFE_F00D));

        // Reset while the read sits in WAIT_DONE.
        stub_lat = 8;
        drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_ready("rst_ready_wait");
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_outputs", all_outs, 128'(0));
        r0 = rsp_cnt; c0 = cmd_cnt;
        @(negedge clk);
        reset = 1'b0;
        stub_lat = 2;
        repeat (12) @(negedge clk);
        check("rst_no_rsp", 128'(rsp_cnt - r0), 128'(0));
        check("rst_no_cmd", 128'(cmd_cnt - c0), 128'(0));
        check("rst_idle_outputs", all_outs, 128'(0));
        drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_ready("post_rst_ready_wait");
        check("post_rst_ready", 128'(req_ready), 128'(2'b10));
        req_valid[1] = 1'b0;
        wait_rsp("post_rst_rsp_wait");
        check("post_rst_rsp_valid", 128'(rsp_valid), 128'(2'b10));
        check("post_rst_rdata", 128'(rsp_rdata), 128'(32'hFFA5_1234));

`ifdef HYPER_ARB_TIMEOUT_EN
        // Controller that never completes: the watchdog must answer.
        repeat (2) @(negedge clk);
        stub_hang = 1'b1;
        drive(0, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_ready("tmo_ready_wait");
        req_valid[0] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < BOUND);
        check("tmo_latency", 128'(n), 128'(TMO + 1));
        check("tmo_rsp_valid", 128'(rsp_valid), 128'(2'b01));
        check("tmo_rdata", 128'(rsp_rdata), 128'(32'hDEAD_BEEF));
        check("tmo_arb_err", 128'(arb_err), 128'(1));
        repeat (3) @(negedge clk);
        check("tmo_arb_err_sticky", 128'(arb_err), 128'(1));
        reset = 1'b1;
        stub_hang = 1'b0;
        @(negedge clk);
        check("tmo_arb_err_cleared", 128'(arb_err), 128'(0));
        reset = 1'b0;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hyper_req_arbiter.md
Name: hyper_req_arbiter

Overview:
- Shares one HyperRAM controller (hyper_xface single-dword command port) between NUM_REQ independent requesters.
- Round-robin arbitration, one outstanding transaction at a time.
- Command/response sequencing: issue, busy tracking, read-data capture, per-requester completion pulse.
- Sits between on-chip masters (test driver, DMA, CPU bridge) and hyper_xface.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with HYPER_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held with fields until req_ready.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  32*NUM_REQ  dword address, requester i at [32i+31:32i].
- req_wdata  in  32*NUM_REQ  write data.
- req_be  in  4*NUM_REQ  write byte enables.
- req_ready  out  NUM_REQ  one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse.
- rsp_rdata  out  32  read data, valid with rsp_valid; shared.
- xf_rd_req / xf_wr_req  out  1  one-cycle command pulses to controller.
- xf_addr  out  32  registered address.
- xf_wr_d  out  32  registered write data.
- xf_wr_byte_en  out  4  registered byte enables.
- xf_rd_d  in  32  controller read data.
- xf_rd_rdy  in  1  controller read-data strobe.
- xf_busy  in  1  controller busy.
- arb_err  out  1  sticky timeout flag; tied 0 without macro.

Behaviour:
- Reset: state IDLE, rr pointer 0, all outputs 0. Reset mid-transaction drops the transaction with no response, and no xf pulse after reset.
- All outputs are registered.
- IDLE:
  - If any req_valid and xf_busy=0, select winner g as the first valid index starting at the rr pointer, wrapping modulo NUM_REQ.
  - Latch g, we, addr, wdata and be into the xf_* registers, then go to ISSUE.
  - If xf_busy=1, stay in IDLE.
- ISSUE (1 cycle): req_ready[g]=1; xf_wr_req=we, xf_rd_req=~we; then go to WAIT_ACK.
- WAIT_ACK: wait for xf_busy=1, then go to WAIT_DONE.
  - If xf_rd_rdy arrives before busy, capture it and treat the read as done.
- WAIT_DONE:
  - Read: on xf_rd_rdy=1, rsp_rdata<=xf_rd_d, then go to RESP.
  - Write: on xf_busy=0, go to RESP.
- RESP (1 cycle): rsp_valid[g]=1; rr pointer <= (g+1) mod NUM_REQ; then go to IDLE.
- rsp_rdata holds its value until the next read completes. For writes, rsp_rdata is unchanged.
- Latency: accept-to-command is 1 cycle (req_ready and the command pulse share a cycle). Minimum turnaround from request to response is 4 cycles plus controller time.
- Simultaneous requests are served strictly in round-robin order; a single requester may be granted back-to-back.
- req_valid deasserted before grant: withdrawn, no effect. Fields changing after grant: ignored.
- Only one transaction is in flight. Other requesters see req_ready=0 until RESP completes.

Optional Feature:
- Macro: HYPER_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on ISSUE and increments in WAIT_ACK and WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP, set arb_err=1 (sticky until reset), and drive rsp_rdata=32'hDEAD_BEEF for reads.
- Without the macro: no counter logic, arb_err constant 0, and the FSM waits indefinitely.

Test Plan:
- Single write: requester 0 writes addr 0x10, data 0xA5A5_1234, be 4'hF → one xf_wr_req pulse with matching fields; rsp_valid[0] pulses after busy falls.
- Write/readback: write 0xCAFE_F00D to 0x20 from requester 1, then read it from requester 0 → rsp_rdata=0xCAFE_F00D with rsp_valid[0].
- Contention: both requesters valid in the same cycle, 3 requests each → grants alternate 0,1,0,1,0,1; no overlapping xf pulses.
- Busy hold-off: force xf_busy=1 in IDLE with req_valid[0]=1 → no req_ready until busy=0, grant on the next cycle.
- Reset mid-read: assert reset during WAIT_DONE → all outputs 0, no rsp_valid; next request completes normally.
- Timeout (HYPER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): stub busy stuck at 1 → rsp_valid after 16 cycles, arb_err=1, rsp_rdata=0xDEAD_BEEF.
